conv_layer_sequencer: RTL and testbench

Layer-level controller that drives one `conv_top` instance through a complete convolution layer. It loads all biases once, then iterates over every output group. For each group it reloads weights, pulses `go`, streams the input feature map and waits for `done`. Between groups it flushes the line buffers with zero beats and pulses a conv-side reset. It sits between the DMA-facing valid/ready sources (bias, weight, pixel) and the `conv_top` write/stream ports.

---
 rtl/conv_layer_sequencer_if.sv | 54 +++++
 rtl/conv_layer_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Handshake and write/stream bundle between the layer sequencer, its DMA-side
// sources and the conv_top write/stream ports.
interface conv_layer_sequencer_if;
    logic [127:0] bias_src_data;
    logic         bias_src_valid;
    logic         bias_src_ready;
    logic [71:0]  wt_src_data;
    logic         wt_src_valid;
    logic         wt_src_ready;
    logic [63:0]  pix_src_data;
    logic         pix_src_valid;
    logic         pix_src_ready;

    logic         bias_wr_en;
    logic [127:0] bias_wr_data;
    logic         bias_wr_addr_rst;
    logic         wt_wr_en;
    logic [71:0]  wt_wr_data;
    logic         wt_wr_addr_rst;
    logic [63:0]  pixel_in;
    logic         pixel_in_valid;
    logic         pixel_in_last;
    logic         conv_go;
    logic         conv_rst;
    logic         conv_done;

    modport master (
        input  bias_src_data, bias_src_valid,
        output bias_src_ready,
        input  wt_src_data, wt_src_valid,
        output wt_src_ready,
        input  pix_src_data, pix_src_valid,
        output pix_src_ready,
        output bias_wr_en, bias_wr_data, bias_wr_addr_rst,
        output wt_wr_en, wt_wr_data, wt_wr_addr_rst,
        output pixel_in, pixel_in_valid, pixel_in_last,
        output conv_go, conv_rst,
        input  conv_done
    );

    modport slave (
        output bias_src_data, bias_src_valid,
        input  bias_src_ready,
        output wt_src_data, wt_src_valid,
        input  wt_src_ready,
        output pix_src_data, pix_src_valid,
        input  pix_src_ready,
        input  bias_wr_en, bias_wr_data, bias_wr_addr_rst,
        input  wt_wr_en, wt_wr_data, wt_wr_addr_rst,
        input  pixel_in, pixel_in_valid, pixel_in_last,
        input  conv_go, conv_rst,
        output conv_done
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Layer controller driving conv_top through bias load, per-group weight load,
// streaming and (with SEQ_FLUSH_EN defined) line-buffer flush plus conv reset.
module conv_layer_sequencer #(
    parameter int unsigned WT_ADDR_WIDTH   = 12,
    parameter int unsigned BIAS_GROUP_BITS = 7,
    parameter int unsigned CRST_CYCLES     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 cfg_co_groups,
    input  logic [9:0]                 cfg_ci_groups,
    input  logic [15:0]                cfg_img_width,
    input  logic [15:0]                cfg_img_height,
    output logic                       busy,
    output logic                       layer_done,
    output logic [7:0]                 cur_og,
    output logic [BIAS_GROUP_BITS-1:0] conv_output_group,
    conv_layer_sequencer_if.master     bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_BIAS_RST,
        S_BIAS_LOAD,
        S_WT_RST,
        S_WT_LOAD,
        S_GO,
        S_STREAM,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE
`ifdef SEQ_FLUSH_EN
        , S_FLUSH
        , S_CRST
`endif
    } state_t;

    state_t state, state_next;

    logic [31:0] cnt;
    logic [31:0] n_bias;
    logic [31:0] n_wt;
    logic [31:0] n_pix;
`ifdef SEQ_FLUSH_EN
    logic [31:0] n_flush;
`endif
    logic [7:0]  co_last;
    logic        done_seen;

    logic bias_ready, wt_ready, pix_ready;
    logic bias_fire, wt_fire, pix_fire, flush_fire;
    logic cnt_inc;
    logic bias_addr_rst_c, wt_addr_rst_c, go_c, crst_c;
    logic accept;

    logic         bias_en_q;
    logic [127:0] bias_data_q;
    logic         wt_en_q;
    logic [71:0]  wt_data_q;
    logic         pix_valid_q;
    logic [63:0]  pix_data_q;
    logic         pix_last_q;

    // Weight base address is fixed at 0, so its width is informational only.
    if (WT_ADDR_WIDTH == 0) begin : g_wt_addr_unused
    end
`ifndef SEQ_FLUSH_EN
    if (CRST_CYCLES == 0) begin : g_crst_unused
    end
`endif

    assign accept = (state == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        busy            = 1'b1;
        layer_done      = 1'b0;
        bias_addr_rst_c = 1'b0;
        wt_addr_rst_c   = 1'b0;
        go_c            = 1'b0;
        crst_c          = 1'b0;
        bias_ready      = 1'b0;
        wt_ready        = 1'b0;
        pix_ready       = 1'b0;
        flush_fire      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_BIAS_RST;
            end
            S_BIAS_RST: begin
                bias_addr_rst_c = 1'b1;
                state_next      = S_BIAS_LOAD;
            end
            // Each load/stream state holds one extra cycle after its last
            // transfer so the registered strobe drains before moving on.
            S_BIAS_LOAD: begin
                bias_ready = (cnt != n_bias);
                if (cnt == n_bias) state_next = S_WT_RST;
            end
            S_WT_RST: begin
                wt_addr_rst_c = 1'b1;
                state_next    = S_WT_LOAD;
            end
            S_WT_LOAD: begin
                wt_ready = (cnt != n_wt);
                if (cnt == n_wt) state_next = S_GO;
            end
            S_GO: begin
                go_c       = 1'b1;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                pix_ready = (cnt != n_pix);
                if (cnt == n_pix) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.conv_done || done_seen) begin
`ifdef SEQ_FLUSH_EN
                    state_next = S_FLUSH;
`else
                    state_next = S_NEXT;
`endif
                end
            end
`ifdef SEQ_FLUSH_EN
            S_FLUSH: begin
                flush_fire = (cnt != n_flush);
                if (cnt == n_flush) state_next = S_CRST;
            end
            S_CRST: begin
                crst_c = 1'b1;
                if (cnt == 32'(CRST_CYCLES - 1)) state_next = S_NEXT;
            end
`endif
            S_NEXT: begin
                state_next = (cur_og == co_last) ? S_DONE : S_WT_RST;
            end
            S_DONE: begin
                busy       = 1'b0;
                layer_done = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign bias_fire = bias_ready && bus.bias_src_valid;
    assign wt_fire   = wt_ready && bus.wt_src_valid;
    assign pix_fire  = pix_ready && bus.pix_src_valid;
    assign cnt_inc   = bias_fire || wt_fire || pix_fire || flush_fire || crst_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            n_bias    <= '0;
            n_wt      <= '0;
            n_pix     <= '0;
`ifdef SEQ_FLUSH_EN
            n_flush   <= '0;
`endif
            co_last   <= '0;
            cur_og    <= '0;
            done_seen <= 1'b0;
        end else begin
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 32'd1;
            end

            if (accept) begin
                n_bias  <= {23'd0, cfg_co_groups, 1'b0};
                n_wt    <= {16'd0, cfg_ci_groups, 6'd0};
                n_pix   <= 32'(cfg_img_width) * 32'(cfg_img_height) * 32'(cfg_ci_groups);
`ifdef SEQ_FLUSH_EN
                n_flush <= 32'(cfg_img_width) * 32'(cfg_ci_groups) * 32'd2 + 32'd4;
`endif
                co_last <= cfg_co_groups - 8'd1;
                cur_og  <= '0;
            end else if (state == S_NEXT && cur_og != co_last) begin
                cur_og <= cur_og + 8'd1;
            end

            if (state == S_GO || state == S_WAIT_DONE) begin
                done_seen <= 1'b0;
            end else if (state == S_STREAM && bus.conv_done) begin
                done_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_en_q   <= 1'b0;
            bias_data_q <= '0;
            wt_en_q     <= 1'b0;
            wt_data_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_last_q  <= 1'b0;
        end else begin
            bias_en_q <= bias_fire;
            if (bias_fire) bias_data_q <= bus.bias_src_data;
            wt_en_q <= wt_fire;
            if (wt_fire) wt_data_q <= bus.wt_src_data;
            pix_valid_q <= pix_fire || flush_fire;
            pix_data_q  <= pix_fire ? bus.pix_src_data : '0;
            pix_last_q  <= pix_fire && (cnt == n_pix - 32'd1);
        end
    end

    assign bus.bias_src_ready   = bias_ready;
    assign bus.wt_src_ready     = wt_ready;
    assign bus.pix_src_ready    = pix_ready;
    assign bus.bias_wr_en       = bias_en_q;
    assign bus.bias_wr_data     = bias_data_q;
    assign bus.bias_wr_addr_rst = bias_addr_rst_c;
    assign bus.wt_wr_en         = wt_en_q;
    assign bus.wt_wr_data       = wt_data_q;
    assign bus.wt_wr_addr_rst   = wt_addr_rst_c;
    assign bus.pixel_in         = pix_data_q;
    assign bus.pixel_in_valid   = pix_valid_q;
    assign bus.pixel_in_last    = pix_last_q;
    assign bus.conv_go          = go_c;
`ifdef SEQ_FLUSH_EN
    assign bus.conv_rst         = crst_c;
`else
    assign bus.conv_rst         = 1'b0;
`endif
    assign conv_output_group    = BIAS_GROUP_BITS'(cur_og);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: pattern sources, strobe scoreboard
// and a minimal conv_top done responder.
module tb_conv_layer_sequencer;

    localparam int CRST = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_co = 8'd1;
    logic [9:0]  cfg_ci = 10'd1;
    logic [15:0] cfg_w = 16'd1;
    logic [15:0] cfg_h = 16'd1;
    logic        busy, layer_done;
    logic [7:0]  cur_og;
    logic [6:0]  conv_output_group;

    conv_layer_sequencer_if bus();

    conv_layer_sequencer #(
        .WT_ADDR_WIDTH  (12),
        .BIAS_GROUP_BITS(7),
        .CRST_CYCLES    (CRST)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .cfg_co_groups    (cfg_co),
        .cfg_ci_groups    (cfg_ci),
        .cfg_img_width    (cfg_w),
        .cfg_img_height   (cfg_h),
        .busy             (busy),
        .layer_done       (layer_done),
        .cur_og           (cur_og),
        .conv_output_group(conv_output_group),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] bias_pat(input int unsigned i);
        return {32'hB1A5_0000 + i, ~i, i ^ 32'h0F0F_0F0F, 32'hCAFE_0000 + i};
    endfunction
    function automatic logic [71:0] wt_pat(input int unsigned i);
        return {i[7:0] ^ 8'hA5, 32'hC0DE_0000 + i, ~i};
    endfunction
    function automatic logic [63:0] pix_pat(input int unsigned i);
        return {32'hF00D_0000 + i, ~i};
    endfunction

    bit rnd_mode   = 1'b0;
    bit early_mode = 1'b0;
    int unsigned cur_np = 0;

    // Sources: a transfer is decided at the negedge from the current ready.
    int unsigned b_tx = 0, w_tx = 0, p_tx = 0;
    initial begin
        bus.bias_src_valid = 1'b0; bus.bias_src_data = '0;
        bus.wt_src_valid   = 1'b0; bus.wt_src_data   = '0;
        bus.pix_src_valid  = 1'b0; bus.pix_src_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_tx = 0; w_tx = 0; p_tx = 0;
            end
            bus.bias_src_valid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.bias_src_data  = bias_pat(b_tx);
            if (bus.bias_src_valid && bus.bias_src_ready) b_tx++;
            bus.wt_src_valid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wt_src_data  = wt_pat(w_tx);
            if (bus.wt_src_valid && bus.wt_src_ready) w_tx++;
            bus.pix_src_valid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pix_src_data  = pix_pat(p_tx);
            if (bus.pix_src_valid && bus.pix_src_ready) p_tx++;
        end
    end

    // Scoreboard and conv_done responder.
    int unsigned b_rx = 0, w_rx = 0, p_rx = 0, pix_in_grp = 0;
    int done_cd = 0;
    int n_bias_s = 0, n_wt_s = 0, n_pix_s = 0, n_last = 0, n_flush = 0;
    int n_go = 0, n_crst = 0, n_done = 0, n_brst = 0, n_wrst = 0;
    int e_bias = 0, e_wt = 0, e_pix = 0, e_last = 0, e_flush = 0;
    logic [6:0] og_at_go [0:63];
    initial begin
        bus.conv_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.conv_done = 1'b0;
            if (!rst_n) begin
                b_rx = 0; w_rx = 0; p_rx = 0; pix_in_grp = 0; done_cd = 0;
            end
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) bus.conv_done = 1'b1;
            end
            if (bus.bias_wr_en) begin
                n_bias_s++;
                if (bus.bias_wr_data !== bias_pat(b_rx)) e_bias++;
                b_rx++;
            end
            if (bus.wt_wr_en) begin
                n_wt_s++;
                if (bus.wt_wr_data !== wt_pat(w_rx)) e_wt++;
                w_rx++;
            end
            if (bus.conv_go) begin
                if (n_go < 64) og_at_go[n_go] = conv_output_group;
                n_go++;
                pix_in_grp = 0;
            end
            if (bus.pixel_in_valid) begin
                if (pix_in_grp < cur_np) begin
                    n_pix_s++;
                    if (bus.pixel_in !== pix_pat(p_rx)) e_pix++;
                    if (bus.pixel_in_last !== (pix_in_grp == cur_np - 1)) e_last++;
                    p_rx++;
                end else begin
                    n_flush++;
                    if (bus.pixel_in !== 64'd0 || bus.pixel_in_last) e_flush++;
                end
                pix_in_grp++;
            end
            if (bus.pixel_in_last) begin
                n_last++;
                if (early_mode) bus.conv_done = 1'b1;
                else done_cd = 3;
            end
            if (bus.conv_rst) n_crst++;
            if (layer_done) n_done++;
            if (bus.bias_wr_addr_rst) n_brst++;
            if (bus.wt_wr_addr_rst) n_wrst++;
        end
    end

    int b_bias, b_wt, b_pix, b_last, b_flush, b_go, b_crst, b_done, b_brst, b_wrst;
    int b_ebias, b_ewt, b_epix, b_elast, b_eflush;
    int x_co, x_ci, x_w, x_h;

    task automatic snapshot();
        b_bias = n_bias_s; b_wt = n_wt_s; b_pix = n_pix_s; b_last = n_last;
        b_flush = n_flush; b_go = n_go; b_crst = n_crst; b_done = n_done;
        b_brst = n_brst; b_wrst = n_wrst;
        b_ebias = e_bias; b_ewt = e_wt; b_epix = e_pix; b_elast = e_last; b_eflush = e_flush;
    endtask

    task automatic start_layer(input int id, input int co, input int ci, input int w, input int h);
        snapshot();
        x_co = co; x_ci = ci; x_w = w; x_h = h;
        cur_np = w * h * ci;
        cfg_co = 8'(co); cfg_ci = 10'(ci); cfg_w = 16'(w); cfg_h = 16'(h);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("L%0d_busy_t1", id), busy, 1'b1);
        check($sformatf("L%0d_bias_rst_t1", id), bus.bias_wr_addr_rst, 1'b1);
        check($sformatf("L%0d_og_start", id), cur_og, 8'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int id);
        int cyc = 0;
        while (n_done == b_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("L%0d_done_timeout", id), n_done == b_done, 1'b0);
        check($sformatf("L%0d_busy_at_done", id), busy, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counts(input int id);
        int exp_flush, exp_crst;
`ifdef SEQ_FLUSH_EN
        exp_flush = x_co * (2 * x_w * x_ci + 4);
        exp_crst  = x_co * CRST;
`else
        exp_flush = 0;
        exp_crst  = 0;
`endif
        check($sformatf("L%0d_bias_cnt", id), n_bias_s - b_bias, 2 * x_co);
        check($sformatf("L%0d_wt_cnt", id), n_wt_s - b_wt, 64 * x_ci * x_co);
        check($sformatf("L%0d_pix_cnt", id), n_pix_s - b_pix, x_w * x_h * x_ci * x_co);
        check($sformatf("L%0d_last_cnt", id), n_last - b_last, x_co);
        check($sformatf("L%0d_flush_cnt", id), n_flush - b_flush, exp_flush);
        check($sformatf("L%0d_crst_cyc", id), n_crst - b_crst, exp_crst);
        check($sformatf("L%0d_go_cnt", id), n_go - b_go, x_co);
        check($sformatf("L%0d_done_cnt", id), n_done - b_done, 1);
        check($sformatf("L%0d_bias_rst_cnt", id), n_brst - b_brst, 1);
        check($sformatf("L%0d_wt_rst_cnt", id), n_wrst - b_wrst, x_co);
        check($sformatf("L%0d_bias_data_err", id), e_bias - b_ebias, 0);
        check($sformatf("L%0d_wt_data_err", id), e_wt - b_ewt, 0);
        check($sformatf("L%0d_pix_data_err", id), e_pix - b_epix, 0);
        check($sformatf("L%0d_last_pos_err", id), e_last - b_elast, 0);
        check($sformatf("L%0d_flush_data_err", id), e_flush - b_eflush, 0);
    endtask

    task automatic run_layer(input int id, input int co, input int ci, input int w, input int h);
        start_layer(id, co, ci, w, h);
        wait_done(id);
        check_counts(id);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_layer_done", layer_done, 1'b0);
        check("rst_cur_og", cur_og, 8'd0);
        check("rst_out_group", conv_output_group, 7'd0);
        check("rst_bias_ready", bus.bias_src_ready, 1'b0);
        check("rst_wt_ready", bus.wt_src_ready, 1'b0);
        check("rst_pix_ready", bus.pix_src_ready, 1'b0);
        check("rst_pix_valid", bus.pixel_in_valid, 1'b0);
        check("rst_go", bus.conv_go, 1'b0);
        check("rst_conv_rst", bus.conv_rst, 1'b0);
        check("rst_bias_addr_rst", bus.bias_wr_addr_rst, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_bias_ready", bus.bias_src_ready, 1'b0);

        // Layer-0 shape, always-valid sources.
        run_layer(1, 2, 1, 10, 10);
        check("L1_og_go0", og_at_go[b_go], 7'd0);
        check("L1_og_go1", og_at_go[b_go + 1], 7'd1);

        // Random valid gaps on all sources.
        rnd_mode = 1'b1;
        run_layer(2, 2, 1, 6, 5);
        rnd_mode = 1'b0;

        // conv_done arrives in the stream drain cycle.
        early_mode = 1'b1;
        run_layer(3, 1, 2, 4, 3);
        early_mode = 1'b0;

        // start and cfg changes while busy are ignored.
        start_layer(4, 2, 1, 5, 4);
        repeat (30) @(negedge clk);
        cfg_co = 8'd5; cfg_w = 16'd9; cfg_ci = 10'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4);
        check_counts(4);

        // Reset during STREAM of group 1.
        start_layer(5, 2, 1, 10, 10);
        cyc = 0;
        while (!((n_go - b_go) == 2 && pix_in_grp >= 10) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("L5_reach_stream_g1", cyc >= 5000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("L5_abort_busy", busy, 1'b0);
        check("L5_abort_pix_valid", bus.pixel_in_valid, 1'b0);
        check("L5_abort_pix_ready", bus.pix_src_ready, 1'b0);
        check("L5_abort_pix_data", bus.pixel_in, 64'd0);
        check("L5_abort_cur_og", cur_og, 8'd0);
        check("L5_abort_layer_done", layer_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("L5_no_layer_done", n_done - b_done, 0);
        run_layer(6, 1, 1, 4, 4);

        // Three groups; flush activity depends on the build.
        run_layer(7, 3, 1, 4, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
